// File: rtl/mod_sub_serial.sv
// Limb-serial modular subtractor: out_data = (opA - opB) mod opM.
// A borrow-chained subtract pass runs first; a carry-chained add of opM follows only when it underflows.
module mod_sub_serial #(
   parameter int WIDTH = 256,
   parameter int LIMB  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [WIDTH-1:0] opM,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   localparam int NLIMB = WIDTH / LIMB;
   localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

   typedef enum logic [1:0] {IDLE, SUB, ADD, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic              borrow_reg, borrow_next;
   logic [WIDTH-1:0]  a_reg, b_reg, m_reg, res_reg;
   logic              load, res_we;
   logic [LIMB-1:0]   limb_val;
   logic [LIMB:0]     sub_full, add_full;
   logic              last_limb;

   logic [LIMB-1:0]   a_limb [NLIMB];
   logic [LIMB-1:0]   b_limb [NLIMB];
   logic [LIMB-1:0]   m_limb [NLIMB];
   logic [LIMB-1:0]   r_limb [NLIMB];

   genvar gi;
   generate
      for (gi = 0; gi < NLIMB; gi++) begin : g_limb
         assign a_limb[gi] = a_reg[gi*LIMB +: LIMB];
         assign b_limb[gi] = b_reg[gi*LIMB +: LIMB];
         assign m_limb[gi] = m_reg[gi*LIMB +: LIMB];
         assign r_limb[gi] = res_reg[gi*LIMB +: LIMB];
      end
   endgenerate

   // borrow_reg doubles as the carry during the ADD pass
   assign sub_full  = {1'b0, a_limb[cnt_reg]} - {1'b0, b_limb[cnt_reg]} - (LIMB+1)'(borrow_reg);
   assign add_full  = {1'b0, r_limb[cnt_reg]} + {1'b0, m_limb[cnt_reg]} + (LIMB+1)'(borrow_reg);
   assign last_limb = (cnt_reg == CW'(NLIMB - 1));

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      borrow_next = borrow_reg;
      load        = 1'b0;
      res_we      = 1'b0;
      limb_val    = sub_full[LIMB-1:0];
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               load        = 1'b1;
               cnt_next    = '0;
               borrow_next = 1'b0;
               state_next  = SUB;
            end
         end
         SUB: begin
            res_we      = 1'b1;
            limb_val    = sub_full[LIMB-1:0];
            borrow_next = sub_full[LIMB];
            if (last_limb) begin
               cnt_next = '0;
               if (sub_full[LIMB]) begin
                  state_next  = ADD;
                  borrow_next = 1'b0;
               end else begin
                  state_next = DONE;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ADD: begin
            res_we      = 1'b1;
            limb_val    = add_full[LIMB-1:0];
            borrow_next = add_full[LIMB];
            if (last_limb) begin
               // carry out of the top limb is dropped: the wrap mod 2^WIDTH gives the residue
               cnt_next    = '0;
               borrow_next = 1'b0;
               state_next  = DONE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         borrow_reg <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         m_reg      <= '0;
         res_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         borrow_reg <= borrow_next;
         if (load) begin
            a_reg <= opA;
            b_reg <= opB;
            m_reg <= opM;
         end
         if (res_we) begin
            for (int i = 0; i < NLIMB; i++) begin
               if (cnt_reg == CW'(i)) res_reg[i*LIMB +: LIMB] <= limb_val;
            end
         end
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign out_data  = res_reg;
endmodule

// File: tb/tb_mod_sub_serial.sv
// Directed bench for mod_sub_serial: hand-computed residues, exact latency, backpressure and reset checks.
module tb_mod_sub_serial;
   localparam int WIDTH = 256;
   localparam logic [WIDTH-1:0] P25519 = {1'b0, {250{1'b1}}, 5'b01101};

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] opA, opB, opM;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   int checks = 0;
   int errors = 0;

   mod_sub_serial #(.WIDTH(WIDTH), .LIMB(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opA(opA), .opB(opB), .opM(opM), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] m);
      opA = a; opB = b; opM = m; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      opA = '0; opB = '0; opM = '0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (out_valid) break;
      end
      check({tag, "_latency"}, WIDTH'(n), WIDTH'(exp_lat));
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] exp, input int exp_lat);
      start_op(a, b, m);
      wait_done(tag, exp_lat);
      check({tag, "_data"}, out_data, exp);
      @(posedge clk); #1;
      check({tag, "_in_ready_after"}, WIDTH'(in_ready), WIDTH'(1));
      check({tag, "_out_valid_after"}, WIDTH'(out_valid), WIDTH'(0));
      $display("op %s: A=%0h B=%0h M=%0h -> %0h", tag, a, b, m, out_data);
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      logic [WIDTH-1:0] eqv;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      opA = '0; opB = '0; opM = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
      check("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
      check("rst_out_data", out_data, '0);
      rst = 1'b0;

      run_op("5m3", 256'd5, 256'd3, 256'd7, 256'd2, 8);
      run_op("3m5", 256'd3, 256'd5, 256'd7, 256'd5, 16);
      run_op("0mPm1", '0, P25519 - 256'd1, P25519, 256'd1, 16);
      run_op("xlimb", 256'h1_0000_0000, 256'd1, 256'h100_0000_0000, 256'hFFFF_FFFF, 8);
      run_op("0m1", '0, 256'd1, P25519, P25519 - 256'd1, 16);
      run_op("hi_borrow", 256'd1, 256'd1 << 200, 256'd1 << 201, (256'd1 << 200) + 256'd1, 16);
      eqv = 256'h7BDF_F316_426F_B2B0_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
      run_op("equal", eqv, eqv, {WIDTH{1'b1}}, '0, 8);

      // Backpressure: result must hold while out_ready is low; in_valid is ignored
      out_ready = 1'b0;
      start_op(256'd100, 256'd1, 256'd1000);
      wait_done("bp", 8);
      check("bp_data", out_data, 256'd99);
      held = out_data;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            opA = 256'd1; opB = 256'd2; opM = 256'd3; in_valid = 1'b1;
         end
         if (i == 6) in_valid = 1'b0;
         @(posedge clk); #1;
         if (i % 5 == 0) begin
            check("bp_hold_valid", WIDTH'(out_valid), WIDTH'(1));
            check("bp_hold_data", out_data, held);
            check("bp_hold_in_ready", WIDTH'(in_ready), WIDTH'(0));
         end
      end
      opA = '0; opB = '0; opM = '0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", WIDTH'(in_ready), WIDTH'(1));
      check("bp_release_out_valid", WIDTH'(out_valid), WIDTH'(0));
      check("bp_retain_data", out_data, 256'd99);
      @(posedge clk); #1;
      check("bp_idle_stays", WIDTH'(in_ready), WIDTH'(1));
      $display("op bp: A=64 B=1 M=3e8 -> %0h held 20 cycles", held);
      run_op("after_bp", 256'd2, 256'd6, 256'd9, 256'd5, 16);

      // Reset during the fourth SUB cycle
      start_op(256'd3, 256'd5, 256'd7);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_in_ready", WIDTH'(in_ready), WIDTH'(1));
      check("midrst_out_valid", WIDTH'(out_valid), WIDTH'(0));
      check("midrst_out_data", out_data, '0);
      $display("op midrst: reset during SUB");
      run_op("post_rst", 256'd3, 256'd5, 256'd7, 256'd5, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mod_sub_serial.md
Name: mod_sub_serial

Overview:
Multi-cycle modular subtractor: computes out_data = (opA - opB) mod opM over 256-bit operands, one LIMB-bit limb per clock. It is the inverse operation of the team's combinational modular adder and serves as the subtraction primitive for ECC point add/double datapaths. Its valid/ready handshakes on both sides let a scheduler stream operations through it. Trading latency for area avoids two full-width 256-bit carry chains.

Parameters:
WIDTH, 256, operand and result width in bits
LIMB, 32, bits processed per cycle; WIDTH must be an integer multiple of LIMB
NLIMB, WIDTH/LIMB (derived, 8), limb count; not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  opA/opB/opM valid
in_ready  output  1  block can accept an operation
opA  input  WIDTH  minuend, precondition opA < opM
opB  input  WIDTH  subtrahend, precondition opB < opM
opM  input  WIDTH  modulus, precondition opM > 0
out_valid  output  1  out_data holds a result
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  (opA - opB) mod opM

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, limb counter=0, borrow/carry=0, operand and result registers=0. Outputs after reset: in_ready=1, out_valid=0, out_data=0. Reset takes priority over all other events, including mid-operation; any in-flight result is discarded.
- States: IDLE, SUB, ADD, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: at an edge with in_valid=1, latch opA, opB and opM into internal registers, clear the counter and borrow, and go to SUB. Inputs may change after the accept edge.
- SUB: each edge computes limb i of D = A - B with a borrow chain (LIMB+1-bit subtract), writes the limb into the result register, and increments the counter. After limb NLIMB-1:
  - final borrow=1 -> go to ADD, clear the counter, carry=0;
  - final borrow=0 -> go to DONE.
- ADD: each edge computes limb i of D + M with a carry chain and writes it back to the result. After limb NLIMB-1, go to DONE. The final carry-out is discarded; the result wraps mod 2^WIDTH, which yields the correct residue.
- DONE: out_data is stable and out_valid=1. At an edge with out_ready=1, go to IDLE; out_valid drops and in_ready rises the next cycle. There is no same-cycle result-accept/new-accept overlap. If out_ready=0, the block holds indefinitely.
- Latency: accept edge k -> out_valid first high after edge k+NLIMB when opA>=opB (8 cycles by default). When opA<opB it is high after edge k+2*NLIMB (16 cycles).
- out_data register: updates only during SUB/ADD; retains the last result in IDLE. Intermediate values are visible on out_data during SUB/ADD and must be ignored while out_valid=0.
- Precondition violation (opA>=opM or opB>=opM): the result is unspecified, but the block must still complete with the same latency rules and never hang.
- opA==opB: result 0, no ADD pass.
- in_valid while busy: ignored; the operand registers are untouched.

Test Plan:
- Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, out_data=0. Then opA=5, opB=3, opM=7 -> out_data=2, out_valid after exactly 8 cycles.
- Borrow path: opA=3, opB=5, opM=7 -> out_data=5, out_valid after exactly 16 cycles. Also opA=0, opB=opM-1 with opM=2^255-19 -> out_data=1.
- Cross-limb borrow: opA=2^32, opB=1, opM=2^40 -> out_data=0xFFFFFFFF. Also opA=0, opB=1, opM=2^255-19 -> out_data=2^255-20 (borrow and carry propagate through all limbs).
- Equal operands: opA=opB=0x7BDFF31642 6FB2B style full 256-bit value, opM larger -> out_data=0 after 8 cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid and out_data stable, in_ready=0, and a new in_valid pulse is ignored. Raise out_ready -> IDLE the next cycle, then accept a new operation.
- Reset mid-operation: assert rst during cycle 4 of SUB -> next cycle IDLE, in_ready=1, out_valid=0, out_data=0. A subsequent opA=3, opB=5, opM=7 returns 5 with normal latency.
